// File: rtl/snes_wrapper.sv
// SNES gamepad poller: drives latch/clock, captures 16 serial bits per frame and publishes
// the six game buttons plus Start as registered, frame-atomic outputs.
module snes_wrapper #(
  parameter int unsigned LATCH_CYCLES = 600,
  parameter int unsigned HALF_CYCLES  = 300,
  parameter int unsigned POLL_CYCLES  = 833333
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       serial_data,
  output logic       snes_clk,
  output logic       data_latch,
  output logic [5:0] output_data,
  output logic       testLED
);

  localparam int unsigned TW = $clog2(POLL_CYCLES);
  localparam int unsigned PW = $clog2(2 * HALF_CYCLES);

  localparam logic [TW-1:0] TLast   = TW'(POLL_CYCLES - 1);
  localparam logic [TW-1:0] TBits   = TW'(LATCH_CYCLES);
  localparam logic [TW-1:0] TIdle   = TW'(LATCH_CYCLES + 32 * HALF_CYCLES);
  localparam logic [PW-1:0] PLast   = PW'(2 * HALF_CYCLES - 1);
  localparam logic [PW-1:0] PSample = PW'(HALF_CYCLES - 1);
  localparam logic [PW-1:0] PHigh   = PW'(HALF_CYCLES);

  logic          r_run;
  logic [TW-1:0] r_t;
  logic [PW-1:0] r_ph;
  logic [3:0]    r_k;
  // [0]=Up [1]=Down [2]=Left [3]=Right [4]=A [5]=B [6]=Start, active high
  logic [6:0]    r_btn;

  logic [TW-1:0] w_t_next;
  logic [PW-1:0] w_ph_next;
  logic          w_bits_next;
  logic          w_sample;

  always_comb begin
    w_t_next = '0;
    if (r_run && (r_t != TLast)) begin
      w_t_next = r_t + TW'(1);
    end
    w_ph_next = '0;
    if ((w_t_next != TBits) && (r_ph != PLast)) begin
      w_ph_next = r_ph + PW'(1);
    end
    w_bits_next = (w_t_next >= TBits) && (w_t_next < TIdle);
    // Last cycle of a low phase: the pad output has settled since the previous rising edge.
    w_sample = r_run && (r_t >= TBits) && (r_t < TIdle) && (r_ph == PSample);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_run       <= 1'b0;
      r_t         <= '0;
      r_ph        <= '0;
      r_k         <= '0;
      r_btn       <= '0;
      data_latch  <= 1'b0;
      snes_clk    <= 1'b1;
      output_data <= '0;
      testLED     <= 1'b0;
    end else begin
      r_run      <= 1'b1;
      r_t        <= w_t_next;
      r_ph       <= w_ph_next;
      data_latch <= (w_t_next < TBits);
      snes_clk   <= !(w_bits_next && (w_ph_next < PHigh));
      if (w_t_next == TBits) begin
        r_k <= '0;
      end else if (w_sample) begin
        r_k <= r_k + 4'd1;
      end
      if (w_sample) begin
        case (r_k)
          4'd0:    r_btn[5] <= ~serial_data;
          4'd3:    r_btn[6] <= ~serial_data;
          4'd4:    r_btn[0] <= ~serial_data;
          4'd5:    r_btn[1] <= ~serial_data;
          4'd6:    r_btn[2] <= ~serial_data;
          4'd7:    r_btn[3] <= ~serial_data;
          4'd8:    r_btn[4] <= ~serial_data;
          default: ;
        endcase
      end
      if (w_t_next == TIdle) begin
        output_data <= r_btn[5:0];
        testLED     <= r_btn[6];
      end
    end
  end

endmodule

// File: tb/tb_snes_wrapper.sv
// Directed bench for snes_wrapper with a behavioural SNES pad model (LATCH=4, HALF=2, POLL=100).
module tb_snes_wrapper;

  logic       clk;
  logic       reset;
  logic       serial_data;
  logic       snes_clk;
  logic       data_latch;
  logic [5:0] output_data;
  logic       testLED;

  logic [15:0] pressed;
  int          idx;
  int          t_cur;
  int          n_fall;
  int          n_tests;
  int          n_fail;

  snes_wrapper #(
    .LATCH_CYCLES(4),
    .HALF_CYCLES (2),
    .POLL_CYCLES (100)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .serial_data(serial_data),
    .snes_clk   (snes_clk),
    .data_latch (data_latch),
    .output_data(output_data),
    .testLED    (testLED)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Pad model: latch loads bit 0, each rising snes_clk advances to the next bit.
  initial idx = 16;
  always @(posedge data_latch or posedge snes_clk) begin
    if (data_latch) idx = 0;
    else idx = idx + 1;
  end
  assign serial_data = (idx < 16) ? ~pressed[idx] : 1'b1;

  always @(negedge snes_clk) n_fall = n_fall + 1;

  task automatic chk_out(input string tag, input logic [5:0] e_out, input logic e_led);
    n_tests++;
    assert (output_data === e_out) else begin
      n_fail++;
      $error("FAIL %s t=%0d output_data=%b expected %b", tag, t_cur, output_data, e_out);
    end
    n_tests++;
    assert (testLED === e_led) else begin
      n_fail++;
      $error("FAIL %s t=%0d testLED=%b expected %b", tag, t_cur, testLED, e_led);
    end
  endtask

  task automatic chk_pins(input string tag);
    int  tf;
    logic e_latch;
    logic e_clk;
    tf      = t_cur % 100;
    e_latch = (tf < 4);
    e_clk   = !((tf >= 4) && (tf < 68) && (((tf - 4) % 4) < 2));
    n_tests++;
    assert (data_latch === e_latch) else begin
      n_fail++;
      $error("FAIL %s t=%0d data_latch=%b expected %b", tag, t_cur, data_latch, e_latch);
    end
    n_tests++;
    assert (snes_clk === e_clk) else begin
      n_fail++;
      $error("FAIL %s t=%0d snes_clk=%b expected %b", tag, t_cur, snes_clk, e_clk);
    end
  endtask

  // Hold reset for 3 cycles, check reset values, release; next negedge is t=0.
  task automatic do_reset(input string tag);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++;
    assert ((data_latch === 1'b0) && (snes_clk === 1'b1)) else begin
      n_fail++;
      $error("FAIL %s latch/clk=%b%b expected 01", tag, data_latch, snes_clk);
    end
    chk_out(tag, 6'b000000, 1'b0);
    reset = 1'b0;
    t_cur = -1;
  endtask

  // Advance n cycles, checking outputs each cycle against pre/post values split at t_upd.
  task automatic run(input string tag, input int n, input int t_upd,
                     input logic [5:0] pre_out, input logic pre_led,
                     input logic [5:0] post_out, input logic post_led);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      t_cur++;
      chk_pins(tag);
      if (t_cur >= t_upd) chk_out(tag, post_out, post_led);
      else chk_out(tag, pre_out, pre_led);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    n_fall  = 0;
    t_cur   = 0;
    reset   = 1'b1;
    pressed = 16'h0000;

    // 1: nothing pressed, check waveform and pulse count
    do_reset("rst1");
    n_fall = 0;
    run("idle", 100, 68, 6'b000000, 1'b0, 6'b000000, 1'b0);
    n_tests++;
    assert (n_fall === 16) else begin
      n_fail++;
      $error("FAIL pulses count=%0d expected 16", n_fall);
    end
    run("idle_next", 1, 68, 6'b000000, 1'b0, 6'b000000, 1'b0);

    // 2: Up + A
    pressed = 16'h0110;
    do_reset("rst2");
    run("up_a", 200, 68, 6'b000000, 1'b0, 6'b010001, 1'b0);

    // 3: Start only
    pressed = 16'h0008;
    do_reset("rst3");
    run("start", 100, 68, 6'b000000, 1'b0, 6'b000000, 1'b1);

    // 4: B + Right, then released before frame 2
    pressed = 16'h0081;
    do_reset("rst4");
    run("b_right", 90, 68, 6'b000000, 1'b0, 6'b101000, 1'b0);
    pressed = 16'h0000;
    run("release", 110, 168, 6'b101000, 1'b0, 6'b000000, 1'b0);

    // 5: all low
    pressed = 16'hFFFF;
    do_reset("rst5");
    run("all", 130, 68, 6'b000000, 1'b0, 6'b111111, 1'b1);

    // 6: reset at t=130 with stale buttons, then a clean frame with only A
    @(negedge clk);
    t_cur++;
    reset = 1'b1;
    @(negedge clk);
    n_tests++;
    assert ((data_latch === 1'b0) && (snes_clk === 1'b1)) else begin
      n_fail++;
      $error("FAIL abort latch/clk=%b%b expected 01", data_latch, snes_clk);
    end
    chk_out("abort", 6'b000000, 1'b0);
    pressed = 16'h0100;
    do_reset("rst6");
    run("after_abort", 100, 68, 6'b000000, 1'b0, 6'b010000, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
